easy_fifo_axis_rr_arb: RTL and testbench

//  Round-robin AXI-Stream arbiter sharing one easy_fifo write port among N_REQ producers.

---
 rtl/easy_fifo_axis_rr_arb.sv | 138 +++++++++++++
 tb/tb_easy_fifo_axis_rr_arb.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/easy_fifo_axis_rr_arb.sv
// easy_fifo_axis_rr_arb
// Round-robin AXI-Stream arbiter that shares one FIFO write port among N_REQ
// producers. A requester is granted for a burst of up to BURST beats. A new
// burst is admitted only when the FIFO occupancy leaves room for a full burst.
// Every release is followed by one idle arbitration cycle.
module easy_fifo_axis_rr_arb #(
  parameter int N_REQ  = 4,
  parameter int DWIDTH = 32,
  parameter int BURST  = 8,
  parameter int DEPTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [N_REQ*DWIDTH-1:0]   s_axis_tdata,
  input  logic [N_REQ-1:0]          s_axis_tvalid,
  output logic [N_REQ-1:0]          s_axis_tready,
  output logic [DWIDTH-1:0]         m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  input  logic [$clog2(DEPTH):0]    fifo_cnt,
  output logic                      grant_valid,
  output logic [$clog2(N_REQ)-1:0]  grant_idx
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int IDX_W = $clog2(N_REQ);
  localparam int BC_W  = $clog2(BURST) + 1;

  localparam logic [BC_W-1:0]  BEAT_LAST = BC_W'(BURST - 1);
  localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(DEPTH);
  localparam logic [CNT_W:0]   BURST_EXT = (CNT_W + 1)'(BURST);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_REQ - 1);

  // Reject parameter sets the arbiter cannot honour.
  generate
    if (BURST < 1 || BURST > DEPTH) begin : g_bad_burst
      $error("easy_fifo_axis_rr_arb: BURST must be within 1..DEPTH");
    end
    if (N_REQ < 2) begin : g_bad_nreq
      $error("easy_fifo_axis_rr_arb: N_REQ must be at least 2");
    end
  endgenerate

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  state_t            state_q;
  logic [IDX_W-1:0]  grant_idx_q;
  logic [IDX_W-1:0]  last_idx_q;
  logic [BC_W-1:0]   beat_cnt_q;

  logic [IDX_W-1:0]  winner_d;
  logic [IDX_W-1:0]  cand_s;
  logic              win_found_s;
  logic [CNT_W:0]    free_s;
  logic              room_s;
  logic              any_valid_s;
  logic              sel_valid_s;

  // Free space is computed one bit wider so an out-of-range count shows as
  // negative (MSB set) instead of wrapping to a large positive value.
  assign free_s      = DEPTH_EXT - {1'b0, fifo_cnt};
  assign room_s      = ~free_s[CNT_W] & (free_s >= BURST_EXT);
  assign any_valid_s = |s_axis_tvalid;
  assign sel_valid_s = s_axis_tvalid[grant_idx_q];

  // Round-robin pick: first valid requester after last_idx, wrapping modulo N_REQ.
  always_comb begin
    winner_d    = '0;
    cand_s      = '0;
    win_found_s = 1'b0;
    for (int k = 1; k <= N_REQ; k++) begin
      cand_s = IDX_W'((int'(last_idx_q) + k) % N_REQ);
      if (!win_found_s && s_axis_tvalid[cand_s]) begin
        winner_d    = cand_s;
        win_found_s = 1'b1;
      end else begin
        win_found_s = win_found_s;
      end
    end
  end

  // Zero-latency datapath: only the granted requester is forwarded and made ready.
  always_comb begin
    m_axis_tdata  = s_axis_tdata[int'(grant_idx_q)*DWIDTH +: DWIDTH];
    m_axis_tvalid = 1'b0;
    s_axis_tready = '0;
    if (state_q == ST_GRANT) begin
      m_axis_tvalid              = sel_valid_s;
      s_axis_tready[grant_idx_q] = m_axis_tready;
    end else begin
      m_axis_tvalid = 1'b0;
      s_axis_tready = '0;
    end
  end

  // Arbitration FSM: admit a burst from IDLE, count beats in GRANT, release on
  // the last beat or when the granted requester stops presenting data.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      grant_idx_q <= '0;
      last_idx_q  <= IDX_LAST;
      beat_cnt_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (any_valid_s && room_s) begin
            state_q     <= ST_GRANT;
            grant_idx_q <= winner_d;
            beat_cnt_q  <= '0;
          end
        end
        ST_GRANT: begin
          if (!sel_valid_s) begin
            state_q    <= ST_IDLE;
            last_idx_q <= grant_idx_q;
          end else if (m_axis_tready) begin
            beat_cnt_q <= beat_cnt_q + BC_W'(1'b1);
            if (beat_cnt_q == BEAT_LAST) begin
              state_q    <= ST_IDLE;
              last_idx_q <= grant_idx_q;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign grant_valid = (state_q == ST_GRANT);
  assign grant_idx   = grant_idx_q;

endmodule

// File: tb/tb_easy_fifo_axis_rr_arb.sv
// Testbench for easy_fifo_axis_rr_arb: a directed vector table, hand-written
// corner sequences and a randomized run checked against a burst-level model.
module tb_easy_fifo_axis_rr_arb;

  localparam int N     = 4;
  localparam int DW    = 32;
  localparam int BURST = 8;
  localparam int DEPTH = 16;
  localparam int CW    = 5;
  localparam int IW    = 2;

  logic            clk = 1'b0;
  logic            rst;
  logic [N*DW-1:0] s_tdata;
  logic [N-1:0]    vld;
  logic [N-1:0]    s_tready;
  logic [DW-1:0]   m_tdata;
  logic            m_tvalid;
  logic            rdy;
  logic [CW-1:0]   fcnt;
  logic            gv;
  logic [IW-1:0]   gidx;

  int checks   = 0;
  int failures = 0;

  // Each producer sends {its index, running sequence number}.
  int seq [N];

  // Reference model state: burst owner, previous owner, beats in this burst.
  bit m_gnt;
  int m_idx;
  int m_last;
  int m_cnt;

  // Values sampled from the DUT in the most recent step.
  logic         smp_gv;
  logic [IW-1:0] smp_idx;
  logic         smp_mv;
  logic [N-1:0] smp_sr;
  logic         smp_beat;
  logic [N-1:0] hs;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < N; i++) s_tdata[i*DW +: DW] = {8'(i), 24'(seq[i])};
  end

  easy_fifo_axis_rr_arb #(.N_REQ(N), .DWIDTH(DW), .BURST(BURST), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_tdata), .s_axis_tvalid(vld), .s_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(rdy),
    .fifo_cnt(fcnt), .grant_valid(gv), .grant_idx(gidx)
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, got, exp);
    end
  endtask

  // One clock cycle: compare at negedge, advance the model, update producers.
  task automatic step();
    logic [N-1:0] exp_sr;
    logic [7:0]   exp_v;
    logic [7:0]   got_v;
    bit           found;
    @(negedge clk);
    smp_gv   = gv;
    smp_idx  = gidx;
    smp_mv   = m_tvalid;
    smp_sr   = s_tready;
    smp_beat = m_tvalid & rdy;
    hs       = s_tready & vld;
    if (!rst) begin
      exp_sr = '0;
      if (m_gnt && rdy) exp_sr[m_idx] = 1'b1;
      exp_v = {m_gnt, IW'(m_idx), (m_gnt && vld[m_idx]), exp_sr};
      got_v = {gv, gidx, m_tvalid, s_tready};
      chk("model_ctrl", 64'(got_v), 64'(exp_v));
      if (m_gnt && vld[m_idx])
        chk("model_data", 64'(m_tdata), 64'({8'(m_idx), 24'(seq[m_idx])}));
    end
    if (rst) begin
      m_gnt = 0; m_idx = 0; m_last = N - 1; m_cnt = 0;
    end else if (!m_gnt) begin
      if (vld != '0 && (DEPTH - int'(fcnt)) >= BURST) begin
        found = 0;
        for (int k = 1; k <= N; k++) begin
          if (!found && vld[(m_last + k) % N]) begin
            m_idx = (m_last + k) % N;
            found = 1;
          end
        end
        m_gnt = 1; m_cnt = 0;
      end
    end else if (!vld[m_idx]) begin
      m_gnt = 0; m_last = m_idx;
    end else if (rdy) begin
      m_cnt++;
      if (m_cnt == BURST) begin
        m_gnt = 0; m_last = m_idx;
      end
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (hs[i]) seq[i]++;
  endtask

  task automatic do_reset();
    rst = 1'b1; vld = '0; rdy = 1'b1; fcnt = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  typedef struct {
    logic [N-1:0]  vld;
    logic          rdy;
    logic [CW-1:0] fcnt;
    logic          gv;
    logic [IW-1:0] idx;
    logic          mv;
    logic [N-1:0]  sr;
  } vec_t;

  vec_t tbl [11];

  initial begin
    int nb, bc, ng, cur, total, bad;
    bit found, prev, started, done;
    int owners [4];
    int bursts [$];
    int rem [N];

    for (int i = 0; i < N; i++) seq[i] = 0;
    m_gnt = 0; m_idx = 0; m_last = N - 1; m_cnt = 0;

    //          vld      rdy   fcnt   gv    idx   mv    sr
    tbl[0]  = '{4'b0010, 1'b1, 5'd9,  1'b0, 2'd0, 1'b0, 4'b0000}; // 7 free: no grant
    tbl[1]  = '{4'b0010, 1'b1, 5'd8,  1'b0, 2'd0, 1'b0, 4'b0000}; // 8 free: admit
    tbl[2]  = '{4'b0010, 1'b0, 5'd8,  1'b1, 2'd1, 1'b1, 4'b0000}; // hold
    tbl[3]  = '{4'b0010, 1'b1, 5'd8,  1'b1, 2'd1, 1'b1, 4'b0010}; // beat
    tbl[4]  = '{4'b0000, 1'b1, 5'd0,  1'b1, 2'd1, 1'b0, 4'b0010}; // valid drop
    tbl[5]  = '{4'b0111, 1'b1, 5'd0,  1'b0, 2'd1, 1'b0, 4'b0000}; // bubble
    tbl[6]  = '{4'b0111, 1'b1, 5'd0,  1'b1, 2'd2, 1'b1, 4'b0100}; // after 1 -> 2
    tbl[7]  = '{4'b0111, 1'b1, 5'd0,  1'b1, 2'd2, 1'b1, 4'b0100};
    tbl[8]  = '{4'b0011, 1'b1, 5'd0,  1'b1, 2'd2, 1'b0, 4'b0100}; // forfeit
    tbl[9]  = '{4'b0011, 1'b1, 5'd0,  1'b0, 2'd2, 1'b0, 4'b0000}; // bubble
    tbl[10] = '{4'b0011, 1'b1, 5'd0,  1'b1, 2'd0, 1'b1, 4'b0001}; // after 2 -> 0

    // Reset state
    do_reset();
    step();
    chk("reset_state", 64'({smp_gv, smp_idx, smp_mv, smp_sr}), 64'd0);

    // Vector table
    for (int t = 0; t < 11; t++) begin
      vld = tbl[t].vld; rdy = tbl[t].rdy; fcnt = tbl[t].fcnt;
      step();
      chk($sformatf("vec%0d", t), 64'({smp_gv, smp_idx, smp_mv, smp_sr}),
          64'({tbl[t].gv, tbl[t].idx, tbl[t].mv, tbl[t].sr}));
    end

    // All four valid: 32 beats in 36 cycles, grants 0,1,2,3
    do_reset();
    vld = 4'hF; rdy = 1'b1; fcnt = '0;
    nb = 0; ng = 0; prev = 0;
    for (int c = 0; c < 36; c++) begin
      step();
      if (smp_beat) nb++;
      if (smp_gv && !prev && ng < 4) begin owners[ng] = int'(smp_idx); ng++; end
      prev = smp_gv;
    end
    chk("t1_beats_in_36", 64'(nb), 64'd32);
    chk("t1_grants", 64'(ng), 64'd4);
    for (int g = 0; g < 4; g++) chk($sformatf("t1_owner%0d", g), 64'(owners[g]), 64'(g));

    // Requester 2 alone sends 20 beats: bursts 8,8,4
    do_reset();
    rdy = 1'b1; fcnt = '0;
    for (int i = 0; i < N; i++) rem[i] = 0;
    rem[2] = 20;
    cur = 0; total = 0; bad = 0;
    bursts.delete();
    for (int c = 0; c < 40; c++) begin
      for (int i = 0; i < N; i++) vld[i] = (rem[i] > 0);
      step();
      if (smp_beat) begin
        cur++; total++;
        if (smp_idx != 2'd2) bad++;
      end
      if (!smp_gv && cur > 0) begin bursts.push_back(cur); cur = 0; end
      for (int i = 0; i < N; i++) if (hs[i]) rem[i]--;
    end
    if (cur > 0) bursts.push_back(cur);
    chk("t2_total", 64'(total), 64'd20);
    chk("t2_wrong_owner", 64'(bad), 64'd0);
    chk("t2_nbursts", 64'(bursts.size()), 64'd3);
    if (bursts.size() == 3) begin
      chk("t2_burst0", 64'(bursts[0]), 64'd8);
      chk("t2_burst1", 64'(bursts[1]), 64'd8);
      chk("t2_burst2", 64'(bursts[2]), 64'd4);
    end

    // Requester 0 with tready toggling: 8 beats, burst held through stalls
    do_reset();
    vld = 4'b0001; rdy = 1'b1; fcnt = '0;
    nb = 0; bc = 0; started = 0; done = 0;
    for (int c = 0; c < 40 && !done; c++) begin
      step();
      if (smp_gv) begin
        started = 1; bc++;
        if (smp_beat) nb++;
      end else if (started) begin
        done = 1;
      end
      rdy = ~rdy;
    end
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_beats", 64'(nb), 64'd8);
    chk("t4_grant_cycles", 64'(bc), 64'd16);

    // Reset mid-burst on requester 3; next grant goes to requester 0
    do_reset();
    vld = 4'b1000; rdy = 1'b1; fcnt = '0;
    nb = 0;
    for (int c = 0; c < 20 && nb < 3; c++) begin
      step();
      if (smp_beat) nb++;
    end
    chk("t5_beats_before_rst", 64'(nb), 64'd3);
    rst = 1'b1;
    step();
    rst = 1'b0; vld = 4'hF;
    step();
    chk("t5_after_rst", 64'({smp_gv, smp_sr}), 64'd0);
    found = 0;
    for (int c = 0; c < 6 && !found; c++) begin
      step();
      if (smp_gv) begin
        found = 1;
        chk("t5_first_grant", 64'(smp_idx), 64'd0);
      end
    end
    if (!found) chk("t5_grant_timeout", 64'd0, 64'd1);

    // Requester 1 forfeits after 2 beats; order afterwards is 2, 0, 1
    do_reset();
    vld = 4'b0010; rdy = 1'b1; fcnt = '0;
    step();
    vld = 4'b0111;
    nb = 0;
    for (int c = 0; c < 10 && nb < 2; c++) begin
      step();
      if (smp_beat && smp_idx == 2'd1) nb++;
    end
    chk("t6_req1_beats", 64'(nb), 64'd2);
    vld = 4'b0101;
    step();
    vld = 4'b0111;
    ng = 0; prev = smp_gv;
    for (int c = 0; c < 40 && ng < 3; c++) begin
      step();
      if (smp_gv && !prev) begin owners[ng] = int'(smp_idx); ng++; end
      prev = smp_gv;
    end
    chk("t6_grants", 64'(ng), 64'd3);
    chk("t6_owner0", 64'(owners[0]), 64'd2);
    chk("t6_owner1", 64'(owners[1]), 64'd0);
    chk("t6_owner2", 64'(owners[2]), 64'd1);

    // Randomized run against the model
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (($urandom % 4) == 0) vld = 4'($urandom);
      rdy  = (($urandom % 4) != 0);
      fcnt = 5'($urandom_range(0, 16));
      rst  = (($urandom % 200) == 0);
      step();
    end
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
